grade_display_sequencer: RTL and testbench

GRADE_DISPLAY_SEQUENCER -- requirements
Module: grade_display_sequencer

---
 rtl/grade_display_sequencer.sv | 124 ++++++++++++
 tb/tb_grade_display_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/grade_display_sequencer.sv
// grade_display_sequencer: buffers 0-9 grades and scans them onto a 7-segment display as digit then pass/fail status (GRADE_DISPLAY_GAP_EN adds a blank gap phase)
module grade_display_sequencer #(
    parameter int DEPTH = 4,
    parameter int DWELL = 4
) (
    input  logic                     clk_2,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    input  logic [3:0]               wr_grade,
    output logic                     wr_ready,
    input  logic                     clear,
    input  logic                     run,
    output logic [7:0]               seg,
    output logic [$clog2(DEPTH)-1:0] idx,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = DWELL > 1 ? $clog2(DWELL) : 1;
    localparam logic [TW-1:0] RELOAD = TW'(DWELL - 1);
    typedef enum logic [1:0] {
        IDLE,
        SHOW_NUM,
        SHOW_STAT
`ifdef GRADE_DISPLAY_GAP_EN
        , GAP
`endif
    } state_t;
    state_t state;
    logic [TW-1:0] timer;
    logic [3:0] mem [DEPTH];
    logic grade_ok;
    logic [AW:0] idx_inc;
    logic [AW-1:0] idx_nxt;
    function automatic logic [7:0] digit(input logic [3:0] g);
        case (g)
            4'd0: digit = 8'h3F;
            4'd1: digit = 8'h06;
            4'd2: digit = 8'h5B;
            4'd3: digit = 8'h4F;
            4'd4: digit = 8'h66;
            4'd5: digit = 8'h6D;
            4'd6: digit = 8'h7D;
            4'd7: digit = 8'h07;
            4'd8: digit = 8'h7F;
            4'd9: digit = 8'h6F;
            default: digit = 8'h00;
        endcase
    endfunction
    function automatic logic [7:0] status(input logic [3:0] g);
        status = g >= 4'd7 ? 8'h77 : g >= 4'd4 ? 8'h71 : 8'h73;
    endfunction
    assign wr_ready = count < (AW + 1)'(DEPTH);
    assign grade_ok = wr_grade <= 4'd9;
    assign idx_inc  = {1'b0, idx} + (AW + 1)'(1);
    assign idx_nxt  = idx_inc >= count ? '0 : idx_inc[AW-1:0];
    // grade storage; only valid grades land at the tail, contents need no reset
    always_ff @(posedge clk_2) begin
        if (wr_valid && wr_ready && !clear && grade_ok) mem[count[AW-1:0]] <= wr_grade;
    end
    // buffer bookkeeping plus the scan FSM with its dwell timer and registered segment output
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            timer <= RELOAD;
            idx   <= '0;
            count <= '0;
            err   <= 1'b0;
            seg   <= '0;
        end else if (clear) begin
            state <= IDLE;
            timer <= RELOAD;
            idx   <= '0;
            count <= '0;
            err   <= 1'b0;
            seg   <= '0;
        end else begin
            if (wr_valid && wr_ready) begin
                if (grade_ok) count <= count + (AW + 1)'(1);
                else err <= 1'b1;
            end
            if (!run || count == '0) begin
                state <= IDLE;
                idx   <= '0;
                timer <= RELOAD;
                seg   <= '0;
            end else if (state == IDLE) begin
                state <= SHOW_NUM;
                timer <= RELOAD;
                seg   <= digit(mem[idx]);
            end else if (timer != '0) begin
                timer <= timer - TW'(1);
            end else begin
                timer <= RELOAD;
                case (state)
                    SHOW_NUM: begin
                        state <= SHOW_STAT;
                        seg   <= status(mem[idx]);
                    end
                    SHOW_STAT: begin
                        idx <= idx_nxt;
`ifdef GRADE_DISPLAY_GAP_EN
                        state <= GAP;
                        seg   <= '0;
`else
                        state <= SHOW_NUM;
                        seg   <= digit(mem[idx_nxt]);
`endif
                    end
`ifdef GRADE_DISPLAY_GAP_EN
                    GAP: begin
                        state <= SHOW_NUM;
                        seg   <= digit(mem[idx]);
                    end
`endif
                    default: begin
                        state <= IDLE;
                        seg   <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_grade_display_sequencer.sv
// tb_grade_display_sequencer: table-driven write checks plus scoreboarded display scan checks
module tb_grade_display_sequencer;
    logic       clk_2 = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic [3:0] wr_grade = 4'd0;
    logic       clear = 1'b0;
    logic       run = 1'b0;
    logic       wr_ready;
    logic       err;
    logic [7:0] seg;
    logic [1:0] idx;
    logic [2:0] count;
    int n_vec = 0;
    int n_err = 0;
    typedef struct {
        logic       v;
        logic [3:0] g;
        logic [2:0] cnt;
        logic       e;
        logic       rdy;
    } row_t;
    typedef struct {
        logic [7:0] seg;
        logic [1:0] idx;
    } exp_t;
    row_t rows[10];
    exp_t q[$];
    grade_display_sequencer #(.DEPTH(4), .DWELL(4)) dut (
        .clk_2(clk_2), .rst_n(rst_n), .wr_valid(wr_valid), .wr_grade(wr_grade),
        .wr_ready(wr_ready), .clear(clear), .run(run), .seg(seg), .idx(idx),
        .count(count), .err(err)
    );
    always #5 clk_2 = ~clk_2;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic step();
        @(posedge clk_2);
        #1;
    endtask
    task automatic push(input logic [7:0] s, input logic [1:0] i, input int n);
        for (int k = 0; k < n; k++) q.push_back('{s, i});
    endtask
    task automatic drain(input string nm);
        exp_t e;
        int c;
        c = 0;
        while (q.size() > 0) begin
            step();
            e = q.pop_front();
            chk($sformatf("%s_seg_%0d", nm, c), 32'(seg), 32'(e.seg));
            chk($sformatf("%s_idx_%0d", nm, c), 32'(idx), 32'(e.idx));
            c++;
        end
    endtask
    task automatic apply(input int a, input int b);
        for (int r = a; r <= b; r++) begin
            wr_valid = rows[r].v;
            wr_grade = rows[r].g;
            step();
            chk($sformatf("row%0d_count", r), 32'(count), 32'(rows[r].cnt));
            chk($sformatf("row%0d_err", r), 32'(err), 32'(rows[r].e));
            chk($sformatf("row%0d_ready", r), 32'(wr_ready), 32'(rows[r].rdy));
        end
        wr_valid = 1'b0;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        rows[0] = '{1'b1, 4'd8,  3'd1, 1'b0, 1'b1};
        rows[1] = '{1'b1, 4'd3,  3'd2, 1'b0, 1'b1};
        rows[2] = '{1'b1, 4'd5,  3'd3, 1'b0, 1'b1};
        rows[3] = '{1'b1, 4'd12, 3'd3, 1'b1, 1'b1};
        rows[4] = '{1'b1, 4'd1,  3'd4, 1'b1, 1'b0};
        rows[5] = '{1'b1, 4'd6,  3'd4, 1'b1, 1'b0};
        rows[6] = '{1'b1, 4'd4,  3'd1, 1'b0, 1'b1};
        rows[7] = '{1'b1, 4'd12, 3'd1, 1'b1, 1'b1};
        rows[8] = '{1'b0, 4'd9,  3'd1, 1'b1, 1'b1};
        rows[9] = '{1'b1, 4'd7,  3'd1, 1'b0, 1'b1};
        #12;
        chk("rst_seg", 32'(seg), 32'h00);
        chk("rst_idx", 32'(idx), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ready", 32'(wr_ready), 32'd1);
        @(negedge clk_2) rst_n = 1'b1;
        apply(0, 2);
        run = 1'b1;
        push(8'h7F, 2'd0, 4); push(8'h77, 2'd0, 4);
        push(8'h4F, 2'd1, 4); push(8'h73, 2'd1, 4);
        push(8'h6D, 2'd2, 4); push(8'h71, 2'd2, 4);
        push(8'h7F, 2'd0, 4); push(8'h77, 2'd0, 4);
        push(8'h4F, 2'd1, 4); push(8'h73, 2'd1, 1);
        drain("scan3");
        run = 1'b0;
        step();
        chk("stop_seg", 32'(seg), 32'h00);
        chk("stop_idx", 32'(idx), 32'd0);
        run = 1'b1;
        step();
        chk("restart_seg", 32'(seg), 32'h7F);
        chk("restart_idx", 32'(idx), 32'd0);
        run = 1'b0;
        step();
        apply(3, 5);
        run = 1'b1;
        push(8'h7F, 2'd0, 4); push(8'h77, 2'd0, 4);
        push(8'h4F, 2'd1, 4); push(8'h73, 2'd1, 4);
        push(8'h6D, 2'd2, 4); push(8'h71, 2'd2, 4);
        push(8'h06, 2'd3, 4); push(8'h73, 2'd3, 4);
        push(8'h7F, 2'd0, 2);
        drain("scan4");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_seg", 32'(seg), 32'h00);
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_err", 32'(err), 32'd0);
        chk("async_rst_idx", 32'(idx), 32'd0);
        chk("async_rst_ready", 32'(wr_ready), 32'd1);
        @(negedge clk_2);
        rst_n = 1'b1;
        run = 1'b0;
        step();
        chk("post_rst_seg", 32'(seg), 32'h00);
        apply(6, 8);
        run = 1'b1;
        step();
        chk("pre_clear_seg", 32'(seg), 32'h66);
        clear = 1'b1;
        wr_valid = 1'b1;
        wr_grade = 4'd2;
        step();
        chk("clear_count", 32'(count), 32'd0);
        chk("clear_err", 32'(err), 32'd0);
        chk("clear_seg", 32'(seg), 32'h00);
        chk("clear_idx", 32'(idx), 32'd0);
        clear = 1'b0;
        wr_valid = 1'b0;
        step();
        chk("after_clear_seg", 32'(seg), 32'h00);
        chk("after_clear_count", 32'(count), 32'd0);
        run = 1'b0;
        step();
        apply(9, 9);
        run = 1'b1;
        for (int r = 0; r < 2; r++) begin
            push(8'h07, 2'd0, 4);
            push(8'h77, 2'd0, 4);
`ifdef GRADE_DISPLAY_GAP_EN
            push(8'h00, 2'd0, 4);
`endif
        end
        drain("single");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
